// File: rtl/key_debounce.sv
// key_debounce: per-channel key synchroniser, bounce filter and press/release pulse generator.
// Auto-repeat on held keys is built only when KEY_DEBOUNCE_AUTOREPEAT_EN is defined.
module key_debounce #(
    parameter int width      = 2,
    parameter int active_low = 1,
    parameter int stable_cyc = 500000,
    parameter int rep_delay  = 25000000,
    parameter int rep_period = 5000000
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [width-1:0] key_raw,
    output logic [width-1:0] key_lvl,
    output logic [width-1:0] key_press,
    output logic [width-1:0] key_rel
);

    localparam int max_dr  = (stable_cyc > rep_delay) ? stable_cyc : rep_delay;
    localparam int max_cyc = (max_dr > rep_period) ? max_dr : rep_period;
    localparam int cw      = $clog2(max_cyc + 1);
    localparam logic [cw-1:0] stable_last = cw'(stable_cyc - 1);

    typedef enum logic [1:0] {REL, PRESS, HELD, RELW} state_t;

    logic [width-1:0] key_in;
    logic [width-1:0] sync1;
    logic [width-1:0] sync2;
    logic [width-1:0] accept;
    logic [width-1:0] rep_pls;
    logic [cw-1:0]    cnt       [width];
    state_t           state     [width];
    state_t           state_nxt [width];

    // Polarity normalisation so that 1 always means pressed downstream
    always_comb key_in = (active_low != 0) ? ~key_raw : key_raw;

    // Two-flop synchroniser, both stages reset to the released value
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    // A new value is accepted on the edge where its mismatch run reaches stable_cyc samples
    always_comb begin
        accept = '0;
        for (int unsigned i = 0; i < width; i++)
            accept[i] = (sync2[i] != key_lvl[i]) && (cnt[i] == stable_last);
    end

    // Filter counter: any agreement restarts the count from zero
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < width; i++)
                cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < width; i++) begin
                if ((sync2[i] == key_lvl[i]) || accept[i])
                    cnt[i] <= '0;
                else
                    cnt[i] <= cnt[i] + cw'(1);
            end
        end
    end

    // Per-channel state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < width; i++)
                state[i] <= REL;
        end else begin
            for (int unsigned i = 0; i < width; i++)
                state[i] <= state_nxt[i];
        end
    end

    // Next-state logic: PRESS and RELW are single-cycle edge states
    always_comb begin
        for (int unsigned i = 0; i < width; i++) begin
            state_nxt[i] = state[i];
            case (state[i])
                REL:     if (accept[i]) state_nxt[i] = PRESS;
                PRESS:   state_nxt[i] = HELD;
                HELD:    if (accept[i]) state_nxt[i] = RELW;
                RELW:    state_nxt[i] = REL;
                default: state_nxt[i] = REL;
            endcase
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        key_lvl   = '0;
        key_press = '0;
        key_rel   = '0;
        for (int unsigned i = 0; i < width; i++) begin
            key_lvl[i]   = (state[i] == PRESS) || (state[i] == HELD);
            key_press[i] = (state[i] == PRESS) || rep_pls[i];
            key_rel[i]   = (state[i] == RELW);
        end
    end

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    localparam logic [cw-1:0] delay_last  = cw'(rep_delay - 1);
    localparam logic [cw-1:0] period_last = cw'(rep_period - 1);

    logic [cw-1:0]    rep_cnt [width];
    logic [width-1:0] rep_armed;

    // rep_cnt counts cycles since the last press pulse; the repeat pulse is registered one
    // cycle ahead from state_nxt so it lands exactly rep_delay/rep_period after the previous one
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < width; i++)
                rep_cnt[i] <= '0;
            rep_armed <= '0;
            rep_pls   <= '0;
        end else begin
            for (int unsigned i = 0; i < width; i++) begin
                if (state_nxt[i] != HELD) begin
                    rep_cnt[i]   <= '0;
                    rep_armed[i] <= 1'b0;
                    rep_pls[i]   <= 1'b0;
                end else if (rep_cnt[i] == (rep_armed[i] ? period_last : delay_last)) begin
                    rep_cnt[i]   <= '0;
                    rep_armed[i] <= 1'b1;
                    rep_pls[i]   <= 1'b1;
                end else begin
                    rep_cnt[i]   <= rep_cnt[i] + cw'(1);
                    rep_pls[i]   <= 1'b0;
                end
            end
        end
    end
`else
    // No auto-repeat: press fires once per accepted press
    always_comb rep_pls = '0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed scenarios plus random key activity,
// checked every cycle against a sample-window reference model.
module tb_key_debounce;

    localparam int SC = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] key_raw;
    logic [1:0] key_lvl;
    logic [1:0] key_press;
    logic [1:0] key_rel;

    int n_assert = 0;
    int n_fail   = 0;

    key_debounce #(
        .width      (2),
        .active_low (0),
        .stable_cyc (SC),
        .rep_delay  (RD),
        .rep_period (RP)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .key_raw   (key_raw),
        .key_lvl   (key_lvl),
        .key_press (key_press),
        .key_rel   (key_rel)
    );

    always #5 clk = ~clk;

    // Reference model: hist[j] holds the raw value sampled j+1 edges ago (zeros after reset)
    logic [1:0] hist [0:SC];
    logic [1:0] m_lvl, m_press, m_rel;
    int         m_age [2];

    task automatic model_reset();
        for (int j = 0; j <= SC; j++) hist[j] = '0;
        m_lvl   = '0;
        m_press = '0;
        m_rel   = '0;
        m_age[0] = 0;
        m_age[1] = 0;
    endtask

    // Level flips when the SC samples seen two to SC+1 edges ago all disagree with it
    task automatic model_step(input logic [1:0] raw);
        for (int c = 0; c < 2; c++) begin
            bit flip;
            flip = 1'b1;
            for (int j = 1; j <= SC; j++)
                if (hist[j][c] == m_lvl[c]) flip = 1'b0;
            m_press[c] = 1'b0;
            m_rel[c]   = 1'b0;
            if (flip) begin
                m_lvl[c] = ~m_lvl[c];
                if (m_lvl[c]) begin
                    m_press[c] = 1'b1;
                    m_age[c]   = 0;
                end else begin
                    m_rel[c] = 1'b1;
                end
            end else if (m_lvl[c]) begin
                m_age[c]++;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
                if (m_age[c] == RD || (m_age[c] > RD && (m_age[c] - RD) % RP == 0))
                    m_press[c] = 1'b1;
`endif
            end
        end
        for (int j = SC; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = raw;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: model sees the raw value present at the edge, outputs checked 1 unit later
    task automatic tick();
        logic [1:0] raw;
        raw = key_raw;
        @(posedge clk);
        model_step(raw);
        #1;
        chk("lvl",   key_lvl,   m_lvl);
        chk("press", key_press, m_press);
        chk("rel",   key_rel,   m_rel);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int presses;
        int rels;
        int run [2];
        logic [5:0]  bpat;
        logic [29:0] rep_seen;
        logic [29:0] rep_exp;

        // Reset with both keys held
        key_raw = 2'b11;
        rstn    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lvl",   key_lvl,   2'b00);
        chk("rst_press", key_press, 2'b00);
        chk("rst_rel",   key_rel,   2'b00);
        rstn = 1'b1;
        n = 0;
        while (key_lvl != 2'b11 && n < 20) begin tick(); n++; end
        chk("rst_latency",     n,         SC + 2);
        chk("rst_press_pulse", key_press, 2'b11);
        tick();

        // Release channel 0
        key_raw = 2'b10;
        n = 0;
        while (key_lvl[0] && n < 20) begin tick(); n++; end
        chk("rel_latency",   n,                     SC + 2);
        chk("rel_pulse0",    {31'd0, key_rel[0]},   1);
        chk("rel_no_press0", {31'd0, key_press[0]}, 0);
        key_raw = 2'b00;
        repeat (SC + 4) tick();

        // Bounce on channel 0: 1,0,1,1,0 then hold 1
        bpat = 6'b101101;
        presses = 0;
        for (int i = 0; i < 5; i++) begin
            key_raw[0] = bpat[i];
            tick();
            presses += int'(key_press[0]);
        end
        key_raw[0] = bpat[5];
        n = 0;
        while (!key_press[0] && n < 20) begin tick(); n++; end
        chk("bounce_quiet",   presses, 0);
        chk("bounce_latency", n,       SC + 2);

        // Hold for 30 cycles after acceptance and record press offsets
        rep_seen    = '0;
        rep_seen[0] = key_press[0];
        for (int k = 1; k < 30; k++) begin
            tick();
            rep_seen[k] = key_press[0];
        end
        rep_exp    = '0;
        rep_exp[0] = 1'b1;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
        for (int k = RD; k < 30; k += RP) rep_exp[k] = 1'b1;
`endif
        chk("repeat_offsets", {2'b00, rep_seen}, {2'b00, rep_exp});

        // Glitch on channel 1: 3 cycles is filtered, 4 cycles is accepted then released
        presses = 0;
        key_raw[1] = 1'b1;
        repeat (3) begin tick(); presses += int'(key_press[1]); end
        key_raw[1] = 1'b0;
        repeat (8) begin tick(); presses += int'(key_press[1] | key_lvl[1]); end
        chk("glitch3_ignored", presses, 0);
        presses = 0;
        rels    = 0;
        key_raw[1] = 1'b1;
        repeat (4) begin tick(); presses += int'(key_press[1]); rels += int'(key_rel[1]); end
        key_raw[1] = 1'b0;
        repeat (12) begin tick(); presses += int'(key_press[1]); rels += int'(key_rel[1]); end
        chk("glitch4_press", presses, 1);
        chk("glitch4_rel",   rels,    1);

        // Release channel 0
        key_raw[0] = 1'b0;
        repeat (SC + 4) tick();

        // Press channel 0 while channel 1 bounces randomly
        key_raw[0] = 1'b1;
        n = 0;
        while (!key_lvl[0] && n < 20) begin
            key_raw[1] = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk("indep_latency", n, SC + 2);

        // Reset in the middle of a release count
        key_raw = 2'b00;
        repeat (3) tick();
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        chk("midrst_lvl",   key_lvl,   2'b00);
        chk("midrst_press", key_press, 2'b00);
        chk("midrst_rel",   key_rel,   2'b00);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        presses = 0;
        repeat (12) begin tick(); presses += int'(key_press != 0) + int'(key_rel != 0); end
        chk("midrst_no_pulse", presses, 0);
        key_raw = 2'b01;
        n = 0;
        while (!key_press[0] && n < 20) begin tick(); n++; end
        chk("requal_latency", n, SC + 2);

        // Random key activity with one asynchronous reset along the way
        run[0] = 0;
        run[1] = 0;
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < 2; c++) begin
                if (run[c] == 0) begin
                    key_raw[c] = ~key_raw[c];
                    run[c]     = int'($urandom_range(1, 7));
                end
                run[c]--;
            end
            if (i == 200) begin
                #2;
                rstn = 1'b0;
                model_reset();
                @(posedge clk);
                #1;
                rstn = 1'b1;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
